// File: rtl/median_stream_ctrl.sv
// rtl/median_stream_ctrl.sv - sequences line-buffer columns into the median filter and tags its output
module median_stream_ctrl #(
  parameter int COLUMN_NUM = 7,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIPE_LAT   = 5,
  parameter int CNT_W      = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic col_valid,
  output logic col_ready,
  output logic filt_refresh,
  output logic pix_valid,
  output logic pix_eol,
  output logic pix_eof,
  output logic busy,
  output logic frame_done,
  output logic err_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
    S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] FIRST_WIN  = CNT_W'(COLUMN_NUM - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          col_q, col_d;
  logic [CNT_W-1:0]          line_q, line_d;
  logic [CNT_W-1:0]          drain_q, drain_d;
  logic                      err_q, err_d;
  // Tag bits: [2] complete window, [1] end of line, [0] end of frame.
  logic [2:0]                tag_d;
  logic [PIPE_LAT-1:0][2:0]  tag_q;
  logic                      tag_clr;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    drain_d      = drain_q;
    err_d        = err_q;
    col_ready    = 1'b0;
    filt_refresh = 1'b0;
    frame_done   = 1'b0;
    tag_clr      = 1'b0;
    tag_d        = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_FLUSH;
          line_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_FLUSH: begin
        filt_refresh = 1'b1;
        col_d        = '0;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        col_ready = 1'b1;
        if (col_valid) begin
          tag_d[2] = (col_q >= FIRST_WIN);
          tag_d[1] = (col_q == LAST_COL);
          tag_d[0] = (col_q == LAST_COL) && (line_q == LAST_LINE);
          if (col_q == LAST_COL) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end else begin
          // The filter cannot stall, so a missing column poisons the whole line.
          state_d = S_ABORT;
          err_d   = 1'b1;
          tag_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          if (line_q == LAST_LINE) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end else begin
            line_d  = line_q + CNT_W'(1);
            state_d = S_FLUSH;
          end
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      S_ABORT: begin
        filt_refresh = 1'b1;
        tag_clr      = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      if (tag_clr) begin
        tag_q <= '0;
      end else begin
        tag_q[0] <= tag_d;
        for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign pix_valid    = tag_q[PIPE_LAT-1][2];
  assign pix_eol      = tag_q[PIPE_LAT-1][2] & tag_q[PIPE_LAT-1][1];
  assign pix_eof      = tag_q[PIPE_LAT-1][2] & tag_q[PIPE_LAT-1][0];
  assign busy         = (state_q != S_IDLE);
  assign err_underrun = err_q;

endmodule
